// File: rtl/npc_pkg.sv
// ---------------------------------------------------------------------------
// npc_pkg
// Shared definitions for the next-PC fetch unit:
//   - flow-op width and encodings (codes 9..15 are unassigned and act as ADD4)
//   - default reset PC and exception vector
//   - selector enum naming which source feeds the PC register on an edge
// ---------------------------------------------------------------------------
package npc_pkg;

    localparam int NPC_OP_W = 4;

    localparam logic [NPC_OP_W-1:0] NPC_OP_ADD4 = 4'd0;
    localparam logic [NPC_OP_W-1:0] NPC_OP_BEQ  = 4'd1;
    localparam logic [NPC_OP_W-1:0] NPC_OP_J    = 4'd2;
    localparam logic [NPC_OP_W-1:0] NPC_OP_JR   = 4'd3;
    localparam logic [NPC_OP_W-1:0] NPC_OP_BNE  = 4'd4;
    localparam logic [NPC_OP_W-1:0] NPC_OP_BLEZ = 4'd5;
    localparam logic [NPC_OP_W-1:0] NPC_OP_BGTZ = 4'd6;
    localparam logic [NPC_OP_W-1:0] NPC_OP_BLTZ = 4'd7;
    localparam logic [NPC_OP_W-1:0] NPC_OP_BGEZ = 4'd8;

    localparam logic [31:0] NPC_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NPC_EXC_VEC  = 32'h0000_4180;

    // Source of the next PC, resolved once per cycle by priority
    typedef enum logic [2:0] {
        NPC_SEL_SEQ,
        NPC_SEL_HOLD,
        NPC_SEL_PEND_LOAD,
        NPC_SEL_TARGET,
        NPC_SEL_PEND,
        NPC_SEL_EXC,
        NPC_SEL_ERET
    } npc_sel_e;

endpackage

// File: rtl/npc_target_calc.sv
// ---------------------------------------------------------------------------
// npc_target_calc
// Purely combinational redirect target and branch-condition evaluation.
// Ports:
//   op_valid_i   op_i/operands valid; when low taken_o is forced to 0
//   op_i         flow op (npc_pkg encodings)
//   branch_pc_i  PC of the instruction carrying op_i
//   imm_i        imm16 in [15:0] for branches, instr_index for J
//   cmp_a_i      rs value (condition operand, JR target)
//   cmp_b_i      rt value (BEQ/BNE)
//   target_o     redirect target for the current op
//   taken_o      op valid and redirect condition true
// ---------------------------------------------------------------------------
module npc_target_calc
    import npc_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                op_valid_i,
    input  logic [NPC_OP_W-1:0] op_i,
    input  logic [ADDR_W-1:0]   branch_pc_i,
    input  logic [25:0]         imm_i,
    input  logic [31:0]         cmp_a_i,
    input  logic [31:0]         cmp_b_i,
    output logic [ADDR_W-1:0]   target_o,
    output logic                taken_o
);

    logic [ADDR_W-1:0] seqPc;
    logic [ADDR_W-1:0] brOffset;
    logic [ADDR_W-1:0] brTarget;
    logic [ADDR_W-1:0] jTarget;
    logic [ADDR_W-1:0] jrTarget;
    logic signed [31:0] aSigned;
    logic               cond;

    assign seqPc    = branch_pc_i + ADDR_W'(4);
    // Word offset, sign-extended to the PC width; wraps mod 2^ADDR_W
    assign brOffset = {{(ADDR_W-18){imm_i[15]}}, imm_i[15:0], 2'b00};
    assign brTarget = seqPc + brOffset;
    // Region bits come from the slot after the jump, not the jump itself
    assign jTarget  = {seqPc[ADDR_W-1:28], imm_i, 2'b00};
    assign jrTarget = {cmp_a_i[ADDR_W-1:2], 2'b00};
    assign aSigned  = signed'(cmp_a_i);

    // Per-op target and condition select; unassigned codes never redirect
    always_comb begin
        cond     = 1'b0;
        target_o = brTarget;
        case (op_i)
            NPC_OP_BEQ:  cond = (cmp_a_i == cmp_b_i);
            NPC_OP_BNE:  cond = (cmp_a_i != cmp_b_i);
            NPC_OP_BLEZ: cond = (aSigned <= 32'sd0);
            NPC_OP_BGTZ: cond = (aSigned >  32'sd0);
            NPC_OP_BLTZ: cond = (aSigned <  32'sd0);
            NPC_OP_BGEZ: cond = (aSigned >= 32'sd0);
            NPC_OP_J: begin
                cond     = 1'b1;
                target_o = jTarget;
            end
            NPC_OP_JR: begin
                cond     = 1'b1;
                target_o = jrTarget;
            end
            default: cond = 1'b0;
        endcase
    end

    assign taken_o = op_valid_i & cond;

endmodule

// File: rtl/npc_fetch_unit.sv
// ---------------------------------------------------------------------------
// npc_fetch_unit
// Architectural PC register and next-PC selection for the MIPS core.
// Handles sequential, conditional-branch, J and JR flow, holds on stall, and
// latches a redirect raised during a stall so it is applied once the stall
// drops. Optional exception entry/return is built when NPC_EXC_EN is defined.
// Ports:
//   clk, reset_n        clock (rising edge), async active-low reset
//   stall_i             hold the PC this cycle
//   op_valid_i, op_i    flow op and its valid
//   branch_pc_i, imm_i  PC of the op and its immediate / instr_index
//   cmp_a_i, cmp_b_i    rs/rt operands (rs is also the JR target)
//   exc_req_i, eret_i   [NPC_EXC_EN] exception request / return
//   epc_o               [NPC_EXC_EN] saved exception PC
//   pc_o, pc4_o         current fetch PC (registered) and pc_o+4
//   taken_o             combinational redirect indication
//   pend_o              a stalled redirect is waiting to be applied
// ---------------------------------------------------------------------------
module npc_fetch_unit
    import npc_pkg::*;
#(
    parameter int          ADDR_W   = 32,
`ifdef NPC_EXC_EN
    parameter logic [31:0] EXC_VEC  = NPC_EXC_VEC,
`endif
    parameter logic [31:0] RESET_PC = NPC_RESET_PC
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                stall_i,
    input  logic                op_valid_i,
    input  logic [NPC_OP_W-1:0] op_i,
    input  logic [ADDR_W-1:0]   branch_pc_i,
    input  logic [25:0]         imm_i,
    input  logic [31:0]         cmp_a_i,
    input  logic [31:0]         cmp_b_i,
`ifdef NPC_EXC_EN
    input  logic                exc_req_i,
    input  logic                eret_i,
    output logic [ADDR_W-1:0]   epc_o,
`endif
    output logic [ADDR_W-1:0]   pc_o,
    output logic [ADDR_W-1:0]   pc4_o,
    output logic                taken_o,
    output logic                pend_o
);

    localparam logic [ADDR_W-1:0] RESET_PC_W = RESET_PC[ADDR_W-1:0];
`ifdef NPC_EXC_EN
    localparam logic [ADDR_W-1:0] EXC_VEC_W  = EXC_VEC[ADDR_W-1:0];
`endif

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pendTgt_q, pendTgt_d;
`ifdef NPC_EXC_EN
    logic [ADDR_W-1:0] epc_q, epc_d;
`endif

    logic [ADDR_W-1:0] pcPlus4;
    logic [ADDR_W-1:0] target;
    logic              taken;
    npc_sel_e          selNext;

    npc_target_calc #(
        .ADDR_W (ADDR_W)
    ) u_target_calc (
        .op_valid_i  (op_valid_i),
        .op_i        (op_i),
        .branch_pc_i (branch_pc_i),
        .imm_i       (imm_i),
        .cmp_a_i     (cmp_a_i),
        .cmp_b_i     (cmp_b_i),
        .target_o    (target),
        .taken_o     (taken)
    );

    assign pcPlus4 = pc_q + ADDR_W'(4);

    // Priority resolution; exception/return are evaluated last so they win
    // over stall and every flow rule, with exception above return
    always_comb begin
        selNext = NPC_SEL_SEQ;
        if (stall_i && taken) begin
            selNext = NPC_SEL_PEND_LOAD;
        end else if (stall_i) begin
            selNext = NPC_SEL_HOLD;
        end else if (taken) begin
            selNext = NPC_SEL_TARGET;
        end else if (pend_q) begin
            selNext = NPC_SEL_PEND;
        end
`ifdef NPC_EXC_EN
        if (eret_i) begin
            selNext = NPC_SEL_ERET;
        end
        if (exc_req_i) begin
            selNext = NPC_SEL_EXC;
        end
`endif
    end

    // Next-state values for the selected source; everything holds by default
    always_comb begin
        pc_d      = pc_q;
        pend_d    = pend_q;
        pendTgt_d = pendTgt_q;
`ifdef NPC_EXC_EN
        epc_d     = epc_q;
`endif
        case (selNext)
            NPC_SEL_SEQ:  pc_d = pcPlus4;
            NPC_SEL_HOLD: pc_d = pc_q;
            NPC_SEL_PEND_LOAD: begin
                pendTgt_d = target;
                pend_d    = 1'b1;
            end
            NPC_SEL_TARGET: begin
                pc_d   = target;
                pend_d = 1'b0;
            end
            NPC_SEL_PEND: begin
                pc_d   = pendTgt_q;
                pend_d = 1'b0;
            end
`ifdef NPC_EXC_EN
            NPC_SEL_EXC: begin
                epc_d  = pc_q;
                pc_d   = EXC_VEC_W;
                pend_d = 1'b0;
            end
            NPC_SEL_ERET: begin
                pc_d   = epc_q;
                pend_d = 1'b0;
            end
`endif
            default: pc_d = pc_q;
        endcase
    end

    // PC, pending latch and optional EPC registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= RESET_PC_W;
            pend_q    <= 1'b0;
            pendTgt_q <= '0;
`ifdef NPC_EXC_EN
            epc_q     <= '0;
`endif
        end else begin
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pendTgt_q <= pendTgt_d;
`ifdef NPC_EXC_EN
            epc_q     <= epc_d;
`endif
        end
    end

    assign pc_o    = pc_q;
    assign pc4_o   = pcPlus4;
    assign taken_o = taken;
    assign pend_o  = pend_q;
`ifdef NPC_EXC_EN
    assign epc_o   = epc_q;
`endif

endmodule

// File: tb/tb_npc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_npc_fetch_unit
// Directed, table-driven bench for npc_fetch_unit with hand-computed
// expectations, followed by hand-written multi-cycle sequences for stall,
// pending redirect, wrap-around and mid-run reset. Exception entry/return is
// exercised when NPC_EXC_EN is defined.
// ---------------------------------------------------------------------------
module tb_npc_fetch_unit;

    localparam logic [3:0] OP_ADD4 = 4'd0;
    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_J    = 4'd2;
    localparam logic [3:0] OP_JR   = 4'd3;
    localparam logic [3:0] OP_BNE  = 4'd4;
    localparam logic [3:0] OP_BLEZ = 4'd5;
    localparam logic [3:0] OP_BGTZ = 4'd6;
    localparam logic [3:0] OP_BLTZ = 4'd7;
    localparam logic [3:0] OP_BGEZ = 4'd8;

    typedef struct {
        string       name;
        logic        stall;
        logic        valid;
        logic [3:0]  op;
        logic [31:0] bpc;
        logic [25:0] imm;
        logic [31:0] a;
        logic [31:0] b;
        logic        expTaken;
        logic [31:0] expPc;
        logic        expPend;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        opValid;
    logic [3:0]  op;
    logic [31:0] branchPc;
    logic [25:0] imm;
    logic [31:0] cmpA;
    logic [31:0] cmpB;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        taken;
    logic        pend;
`ifdef NPC_EXC_EN
    logic        excReq;
    logic        eret;
    logic [31:0] epc;
`endif

    int checks = 0;
    int errors = 0;
    vec_t vecs[16];

    always #5 clk = ~clk;

    npc_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .stall_i     (stall),
        .op_valid_i  (opValid),
        .op_i        (op),
        .branch_pc_i (branchPc),
        .imm_i       (imm),
        .cmp_a_i     (cmpA),
        .cmp_b_i     (cmpB),
`ifdef NPC_EXC_EN
        .exc_req_i   (excReq),
        .eret_i      (eret),
        .epc_o       (epc),
`endif
        .pc_o        (pc),
        .pc4_o       (pc4),
        .taken_o     (taken),
        .pend_o      (pend)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic v, input logic [3:0] o,
                                 input logic [31:0] bpc, input logic [25:0] im,
                                 input logic [31:0] a, input logic [31:0] b);
        stall    = s;
        opValid  = v;
        op       = o;
        branchPc = bpc;
        imm      = im;
        cmpA     = a;
        cmpB     = b;
    endtask

    // One cycle: drive at posedge+1, check taken before the edge, then state after it
    task automatic step(input string name, input logic s, input logic v, input logic [3:0] o,
                        input logic [31:0] bpc, input logic [25:0] im,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic expTaken, input logic [31:0] expPc, input logic expPend);
        applyStimulus(s, v, o, bpc, im, a, b);
        #1;
        checkOutput({name, " taken"}, {31'b0, taken}, {31'b0, expTaken});
        @(posedge clk);
        #1;
        checkOutput({name, " pc"}, pc, expPc);
        checkOutput({name, " pc4"}, pc4, expPc + 32'd4);
        checkOutput({name, " pend"}, {31'b0, pend}, {31'b0, expPend});
    endtask

    task automatic idle(input string name, input logic [31:0] expPc);
        step(name, 1'b0, 1'b0, OP_ADD4, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, expPc, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        //                name     stl   vld   op       bpc            imm         a              b             tkn   expPc          pend
        vecs[0]  = '{"seq0",   1'b0, 1'b0, OP_ADD4, 32'h0,         26'h0,      32'h0,         32'h0,        1'b0, 32'h0000_3004, 1'b0};
        vecs[1]  = '{"seq1",   1'b0, 1'b0, OP_ADD4, 32'h0,         26'h0,      32'h0,         32'h0,        1'b0, 32'h0000_3008, 1'b0};
        vecs[2]  = '{"beqT",   1'b0, 1'b1, OP_BEQ,  32'h0000_3010, 26'hFFFE,   32'd5,         32'd5,        1'b1, 32'h0000_300C, 1'b0};
        vecs[3]  = '{"seq2",   1'b0, 1'b0, OP_ADD4, 32'h0,         26'h0,      32'h0,         32'h0,        1'b0, 32'h0000_3010, 1'b0};
        vecs[4]  = '{"beqN",   1'b0, 1'b1, OP_BEQ,  32'h0000_3010, 26'hFFFE,   32'd5,         32'd6,        1'b0, 32'h0000_3014, 1'b0};
        vecs[5]  = '{"j",      1'b0, 1'b1, OP_J,    32'h0000_3020, 26'h0000C40,32'h0,         32'h0,        1'b1, 32'h0000_3100, 1'b0};
        vecs[6]  = '{"jr",     1'b0, 1'b1, OP_JR,   32'h0000_3100, 26'h0,      32'h0000_3403, 32'h0,        1'b1, 32'h0000_3400, 1'b0};
        vecs[7]  = '{"bneT",   1'b0, 1'b1, OP_BNE,  32'h0000_3400, 26'h0010,   32'd1,         32'd2,        1'b1, 32'h0000_3444, 1'b0};
        vecs[8]  = '{"blezZ",  1'b0, 1'b1, OP_BLEZ, 32'h0000_3444, 26'h0001,   32'h0,         32'h0,        1'b1, 32'h0000_344C, 1'b0};
        vecs[9]  = '{"blezP",  1'b0, 1'b1, OP_BLEZ, 32'h0000_344C, 26'h0001,   32'd1,         32'h0,        1'b0, 32'h0000_3450, 1'b0};
        vecs[10] = '{"bgezN",  1'b0, 1'b1, OP_BGEZ, 32'h0000_3450, 26'h0001,   32'hFFFF_FFFF, 32'h0,        1'b0, 32'h0000_3454, 1'b0};
        vecs[11] = '{"bltzM",  1'b0, 1'b1, OP_BLTZ, 32'h0000_3454, 26'hFFFF,   32'h8000_0000, 32'h0,        1'b1, 32'h0000_3454, 1'b0};
        vecs[12] = '{"bgtzM",  1'b0, 1'b1, OP_BGTZ, 32'h0000_3454, 26'h0001,   32'h8000_0000, 32'h0,        1'b0, 32'h0000_3458, 1'b0};
        vecs[13] = '{"invJ",   1'b0, 1'b0, OP_J,    32'h0000_3458, 26'h0,      32'h0,         32'h0,        1'b0, 32'h0000_345C, 1'b0};
        vecs[14] = '{"op9",    1'b0, 1'b1, 4'd9,    32'h0000_345C, 26'h0010,   32'h0,         32'h0,        1'b0, 32'h0000_3460, 1'b0};
        vecs[15] = '{"bgezZ",  1'b0, 1'b1, OP_BGEZ, 32'h0000_3460, 26'h0100,   32'h0,         32'h0,        1'b1, 32'h0000_3864, 1'b0};

`ifdef NPC_EXC_EN
        excReq = 1'b0;
        eret   = 1'b0;
`endif
        reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, OP_ADD4, 32'h0, 26'h0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        checkOutput("reset pc", pc, 32'h0000_3000);
        checkOutput("reset pc4", pc4, 32'h0000_3004);
        checkOutput("reset pend", {31'b0, pend}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].name, vecs[i].stall, vecs[i].valid, vecs[i].op, vecs[i].bpc,
                 vecs[i].imm, vecs[i].a, vecs[i].b, vecs[i].expTaken, vecs[i].expPc,
                 vecs[i].expPend);
        end

        // Stalled redirect is latched, survives further stall cycles, then lands
        step("stlBgtz", 1'b1, 1'b1, OP_BGTZ, 32'h0000_3000, 26'h0004, 32'd1, 32'h0, 1'b1, 32'h0000_3864, 1'b1);
        step("stlHold1", 1'b1, 1'b0, OP_ADD4, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 32'h0000_3864, 1'b1);
        step("stlHold2", 1'b1, 1'b0, OP_ADD4, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 32'h0000_3864, 1'b1);
        idle("pendApply", 32'h0000_3014);

        // Newer stalled redirect overwrites older; not-taken op under stall leaves it
        step("ovrJ", 1'b1, 1'b1, OP_J, 32'h0000_3020, 26'h0000C40, 32'h0, 32'h0, 1'b1, 32'h0000_3014, 1'b1);
        step("ovrBeq", 1'b1, 1'b1, OP_BEQ, 32'h0000_3010, 26'hFFFE, 32'd7, 32'd7, 1'b1, 32'h0000_3014, 1'b1);
        step("ovrBneN", 1'b1, 1'b1, OP_BNE, 32'h0000_3010, 26'h0040, 32'd7, 32'd7, 1'b0, 32'h0000_3014, 1'b1);
        idle("ovrApply", 32'h0000_300C);

        // Live redirect beats pending one, and the pending one is dropped
        step("t5Stall", 1'b1, 1'b1, OP_BGTZ, 32'h0000_3000, 26'h0004, 32'd1, 32'h0, 1'b1, 32'h0000_300C, 1'b1);
        step("t5Jr", 1'b0, 1'b1, OP_JR, 32'h0000_3010, 26'h0, 32'h0000_3800, 32'h0, 1'b1, 32'h0000_3800, 1'b0);
        idle("t5Seq", 32'h0000_3804);
        step("t5BltzZ", 1'b0, 1'b1, OP_BLTZ, 32'h0000_3804, 26'h0004, 32'h0, 32'h0, 1'b0, 32'h0000_3808, 1'b0);
        step("stlInv", 1'b1, 1'b0, OP_J, 32'h0000_3808, 26'h0000100, 32'h0, 32'h0, 1'b0, 32'h0000_3808, 1'b0);
        idle("stlInvSeq", 32'h0000_380C);

        // Wrap-around and J region bits
        step("jrTop", 1'b0, 1'b1, OP_JR, 32'h0000_380C, 26'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        idle("wrap", 32'h0000_0000);
        step("jrHi", 1'b0, 1'b1, OP_JR, 32'h0, 26'h0, 32'hF000_0000, 32'h0, 1'b1, 32'hF000_0000, 1'b0);
        step("jRegion", 1'b0, 1'b1, OP_J, 32'hF000_0010, 26'h0000010, 32'h0, 32'h0, 1'b1, 32'hF000_0040, 1'b0);

        // Mid-run async reset with a pending redirect outstanding
        step("preRst", 1'b1, 1'b1, OP_BGTZ, 32'h0000_3000, 26'h0004, 32'd1, 32'h0, 1'b1, 32'hF000_0040, 1'b1);
        applyStimulus(1'b0, 1'b0, OP_ADD4, 32'h0, 26'h0, 32'h0, 32'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("midRst pc", pc, 32'h0000_3000);
        checkOutput("midRst pend", {31'b0, pend}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle("postRst0", 32'h0000_3004);
        idle("postRst1", 32'h0000_3008);

`ifdef NPC_EXC_EN
        stall  = 1'b1;
        excReq = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("exc pc", pc, 32'h0000_4180);
        checkOutput("exc epc", epc, 32'h0000_3008);
        checkOutput("exc pend", {31'b0, pend}, 32'h0);
        stall  = 1'b0;
        excReq = 1'b0;
        eret   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("eret pc", pc, 32'h0000_3008);
        eret = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
